// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH stages of payload, control and valid,
// with stall (hold), flush (bubble) and a registered occupancy count for hazard logic.
module pipe_stage_reg #(
    parameter int DATA_W = 69,
    parameter int CTRL_W = 4,
    parameter int DEPTH  = 1,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic              stall,
    input  logic              flush,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DEPTH-1:0]  stage_valid,
    output logic [CNT_W-1:0]  occupancy
);

    if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
        $error("pipe_stage_reg: DEPTH must be in 1..8");
    end
    if ((64'd1 << CNT_W) <= 64'(DEPTH)) begin : g_bad_cnt_w
        $error("pipe_stage_reg: CNT_W too narrow to count DEPTH stages");
    end

    logic [DATA_W-1:0] r_data [DEPTH];
    logic [CTRL_W-1:0] r_ctrl [DEPTH];
    logic [DEPTH-1:0]  r_valid;
    logic [CNT_W-1:0]  r_occ;
    logic [DEPTH-1:0]  w_valid_nxt;

    function automatic logic [CNT_W-1:0] popcount(input logic [DEPTH-1:0] v);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int k = 0; k < DEPTH; k++) begin
            n = n + CNT_W'(v[k]);
        end
        return n;
    endfunction

    // Next valid vector is shared by the stage registers and the occupancy count,
    // so occupancy always matches stage_valid on the same edge.
    always_comb begin
        w_valid_nxt = r_valid;
        if (flush) begin
            w_valid_nxt = '0;
        end else if (!stall) begin
            w_valid_nxt[0] = in_valid;
            for (int k = 1; k < DEPTH; k++) begin
                w_valid_nxt[k] = r_valid[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_data[k] <= '0;
                r_ctrl[k] <= '0;
            end
            r_valid <= '0;
            r_occ   <= '0;
        end else begin
            r_valid <= w_valid_nxt;
            r_occ   <= popcount(w_valid_nxt);
            if (flush) begin
                // Payload is left in place; only control is scrubbed with the valid bits.
                for (int k = 0; k < DEPTH; k++) begin
                    r_ctrl[k] <= '0;
                end
            end else if (!stall) begin
                r_data[0] <= in_data;
                r_ctrl[0] <= in_valid ? in_ctrl : '0;
                for (int k = 1; k < DEPTH; k++) begin
                    r_data[k] <= r_data[k-1];
                    r_ctrl[k] <= r_ctrl[k-1];
                end
            end
        end
    end

    assign out_valid   = r_valid[DEPTH-1];
    assign out_data    = r_data[DEPTH-1];
    assign out_ctrl    = r_ctrl[DEPTH-1];
    assign stage_valid = r_valid;
    assign occupancy   = r_occ;

endmodule
